// File: rtl/pa_clic_arb.sv
// pa_clic_arb: CLIC interrupt arbiter.
// Stage 1 picks the highest-ranked requesting kid. On equal ranks the lowest
// index wins. The pick is registered as the candidate every cycle.
// Stage 2 filters the candidate against the global enable and the threshold.
// It presents the winner to the CPU through a valid/ack handshake. When the
// CPU accepts, the winning kid gets a one-cycle ack pulse, followed by one
// blackout cycle so the kid's cleared pending can reach the candidate.

// Per-kid sort key: {req, rank masked by req}.
// A requesting kid with rank 0 still beats any idle kid.
module pa_clic_arb_kid #(
  parameter int W = 4
) (
  input  logic         req,
  input  logic [W-1:0] rank,
  output logic [W:0]   key
);
  assign key = {req, rank & {W{req}}};
endmodule

module pa_clic_arb #(
  parameter int INT_NUM        = 16,
  parameter int ID_WIDTH       = 4,
  parameter int CLICINTCTLBITS = 3
) (
  input  logic                      clic_clk,
  input  logic                      cpurst,
  input  logic [INT_NUM-1:0]        kid_arb_int_req,
  input  logic [INT_NUM*(CLICINTCTLBITS+1)-1:0] kid_arb_int_all,
  input  logic [INT_NUM-1:0]        kid_arb_int_hv,
  input  logic                      ctrl_arb_int_en,
  input  logic [7:0]                ctrl_arb_thresh,
  input  logic                      cpu_clic_int_ack,
  output logic                      clic_cpu_int_vld,
  output logic [ID_WIDTH-1:0]       clic_cpu_int_id,
  output logic [7:0]                clic_cpu_int_il,
  output logic                      clic_cpu_int_hv,
  output logic [INT_NUM-1:0]        arb_kid_ack_int
);
  localparam int W  = CLICINTCTLBITS + 1;
  localparam int KW = W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] ACK     = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  // ---------------- stage 1: select ----------------
  logic [INT_NUM-1:0][KW-1:0] kid_key;

  for (genvar gi = 0; gi < INT_NUM; gi++) begin : g_kid
    pa_clic_arb_kid #(.W(W)) u_kid (
      .req  (kid_arb_int_req[gi]),
      .rank (kid_arb_int_all[gi*W +: W]),
      .key  (kid_key[gi])
    );
  end

  logic [KW-1:0]       best_key;
  logic [ID_WIDTH-1:0] best_id;
  logic                best_hv;

  // Linear max search. A strict compare keeps the lowest index on ties.
  always_comb begin
    best_key = '0;
    best_id  = '0;
    best_hv  = 1'b0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (kid_key[i] > best_key) begin
        best_key = kid_key[i];
        best_id  = ID_WIDTH'(i);
        best_hv  = kid_arb_int_hv[i];
      end
    end
  end

  // Only the level bits of the rank are kept. The mode bit matters for
  // ordering, which is already resolved above.
  logic                      cand_vld;
  logic [ID_WIDTH-1:0]       cand_id;
  logic [CLICINTCTLBITS-1:0] cand_rank;
  logic                      cand_hv;

  // Candidate register: follows the search result every cycle.
  always_ff @(posedge clic_clk) begin
    if (cpurst) begin
      cand_vld  <= 1'b0;
      cand_id   <= '0;
      cand_rank <= '0;
      cand_hv   <= 1'b0;
    end else begin
      cand_vld  <= best_key[KW-1];
      cand_id   <= best_id;
      cand_rank <= best_key[CLICINTCTLBITS-1:0];
      cand_hv   <= best_hv;
    end
  end

  // ---------------- level and eligibility ----------------
  logic [7:0] cand_prio8;
  logic [7:0] cand_il;
  logic       elig;

  // Level = implemented priority bits left-justified, with the unimplemented
  // low bits filled with ones.
  always_comb begin
    cand_prio8 = 8'(cand_rank);
    cand_il    = (cand_prio8 << (8 - CLICINTCTLBITS)) | (8'hFF >> CLICINTCTLBITS);
  end

  assign elig = cand_vld && ctrl_arb_int_en && (cand_il > ctrl_arb_thresh);

  // ---------------- stage 2: handshake FSM ----------------
  logic [1:0] state, state_nxt;
  logic       load;

  // Next-state logic. A CPU ack wins over withdrawal and preemption.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (elig) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (cpu_clic_int_ack)              state_nxt = ACK;
        else if (!elig)                    state_nxt = IDLE;
        else if (cand_id != clic_cpu_int_id) load    = 1'b1;
      end
      ACK:     state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clic_clk) begin
    if (cpurst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Presented-interrupt registers. They change only on a load, so they hold
  // through ACK and DRAIN and the ack decode sees the accepted ID.
  always_ff @(posedge clic_clk) begin
    if (cpurst) begin
      clic_cpu_int_id <= '0;
      clic_cpu_int_il <= 8'h00;
      clic_cpu_int_hv <= 1'b0;
    end else if (load) begin
      clic_cpu_int_id <= cand_id;
      clic_cpu_int_il <= cand_il;
      clic_cpu_int_hv <= cand_hv;
    end
  end

  assign clic_cpu_int_vld = (state == PRESENT);

  // One-hot ack to the accepted kid for the single ACK cycle.
  // A reset in that cycle cancels the pulse.
  always_comb begin
    arb_kid_ack_int = '0;
    for (int i = 0; i < INT_NUM; i++)
      arb_kid_ack_int[i] = (state == ACK) && !cpurst && (clic_cpu_int_id == ID_WIDTH'(i));
  end
endmodule

// File: tb/tb_pa_clic_arb.sv
// Testbench for pa_clic_arb: table vectors, directed handshake sequences, and
// random stimulus against a cycle-level reference model.
module tb_pa_clic_arb;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int PB = 3;

  logic          clk;
  logic          cpurst;
  logic [N-1:0]  req;
  logic [N*4-1:0] all;
  logic [N-1:0]  hv;
  logic          en;
  logic [7:0]    th;
  logic          ack;
  logic          vld;
  logic [IW-1:0] id;
  logic [7:0]    il;
  logic          hv_o;
  logic [N-1:0]  ackv;

  int tests = 0;
  int fails = 0;

  pa_clic_arb #(.INT_NUM(N), .ID_WIDTH(IW), .CLICINTCTLBITS(PB)) dut (
    .clic_clk         (clk),
    .cpurst           (cpurst),
    .kid_arb_int_req  (req),
    .kid_arb_int_all  (all),
    .kid_arb_int_hv   (hv),
    .ctrl_arb_int_en  (en),
    .ctrl_arb_thresh  (th),
    .cpu_clic_int_ack (ack),
    .clic_cpu_int_vld (vld),
    .clic_cpu_int_id  (id),
    .clic_cpu_int_il  (il),
    .clic_cpu_int_hv  (hv_o),
    .arb_kid_ack_int  (ackv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [63:0] all;
    logic [15:0] hv;
    logic        en;
    logic [7:0]  th;
    logic        ev;
    logic [3:0]  eid;
    logic [7:0]  eil;
    logic        ehv;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [63:0] rk(int i, logic [3:0] r);
    return 64'(r) << (4 * i);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [15:0] r, logic [63:0] a, logic [15:0] h, logic e, logic [7:0] t);
    req = r; all = a; hv = h; en = e; th = t;
  endtask

  task automatic clear_idle();
    drive(16'h0, 64'h0, 16'h0, 1'b1, 8'h00);
    ack = 1'b0;
    tick(3);
  endtask

  // ---------------- reference model ----------------
  bit m_pres;
  int m_blk;   // remaining blackout cycles after an accept: 2 = ack cycle, 1 = drain
  bit m_cvld;
  int m_cid;
  int m_crank;
  bit m_chv;
  int o_id;
  int o_il;
  bit o_hv;

  function automatic int lvl(int rank);
    return ((rank % (1 << PB)) << (8 - PB)) + ((1 << (8 - PB)) - 1);
  endfunction

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_step();
    bit el;
    int best;
    int sc;
    el = m_cvld && en && (lvl(m_crank) > int'(th));
    if (cpurst) begin
      m_pres = 0; m_blk = 0; o_id = 0; o_il = 0; o_hv = 0;
    end else if (m_blk > 0) begin
      m_blk--;
    end else if (m_pres) begin
      if (ack) begin
        m_pres = 0; m_blk = 2;
      end else if (!el) begin
        m_pres = 0;
      end else if (m_cid != o_id) begin
        o_id = m_cid; o_il = lvl(m_crank); o_hv = m_chv;
      end
    end else if (el) begin
      m_pres = 1; o_id = m_cid; o_il = lvl(m_crank); o_hv = m_chv;
    end
    // Winner score = rank*64 + (63 - index), so the largest rank wins and the
    // lowest index breaks ties.
    best = -1;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        sc = int'(all[i*4 +: 4]) * 64 + (63 - i);
        if (sc > best) best = sc;
      end
    end
    if (cpurst || best < 0) begin
      m_cvld = 0; m_cid = 0; m_crank = 0; m_chv = 0;
    end else begin
      m_cvld = 1; m_crank = best / 64; m_cid = 63 - (best % 64); m_chv = hv[m_cid];
    end
  endtask

  initial begin
    logic [15:0] exp_ack;
    // Vectors: inputs, then expected vld, id, il and hv two cycles later.
    tbl[0]  = '{16'h0020, rk(5, 4'hB), 16'h0000, 1'b1, 8'h00, 1'b1, 4'd5,  8'h7F, 1'b0};
    tbl[1]  = '{16'h1208, rk(3, 4'hE) | rk(9, 4'hE) | rk(12, 4'hD), 16'h0200, 1'b1, 8'h00, 1'b1, 4'd3, 8'hDF, 1'b0};
    tbl[2]  = '{16'h0004, rk(2, 4'hA), 16'h0000, 1'b1, 8'h5F, 1'b0, 4'd0,  8'h00, 1'b0};
    tbl[3]  = '{16'h0004, rk(2, 4'hA), 16'h0000, 1'b1, 8'h5E, 1'b1, 4'd2,  8'h5F, 1'b0};
    tbl[4]  = '{16'h0002, rk(1, 4'hF), 16'h0000, 1'b0, 8'h00, 1'b0, 4'd0,  8'h00, 1'b0};
    tbl[5]  = '{16'h8001, rk(15, 4'h7) | rk(0, 4'h8), 16'h8000, 1'b1, 8'h00, 1'b1, 4'd0, 8'h1F, 1'b0};
    tbl[6]  = '{16'h8000, rk(15, 4'h1), 16'h8000, 1'b1, 8'h00, 1'b1, 4'd15, 8'h3F, 1'b1};
    tbl[7]  = '{16'h0010, rk(4, 4'hF), 16'h0000, 1'b1, 8'hFF, 1'b0, 4'd0,  8'h00, 1'b0};
    tbl[8]  = '{16'h0000, 64'h0,       16'h0000, 1'b1, 8'h00, 1'b0, 4'd0,  8'h00, 1'b0};
    tbl[9]  = '{16'h0040, 64'h0,       16'h0000, 1'b1, 8'h00, 1'b1, 4'd6,  8'h1F, 1'b0};
    tbl[10] = '{16'h0008, rk(3, 4'h7), 16'h0008, 1'b1, 8'hFE, 1'b1, 4'd3,  8'hFF, 1'b1};

    // Reset with an active request: outputs must stay cleared.
    cpurst = 1'b1; ack = 1'b0;
    drive(16'h0020, rk(5, 4'hB), 16'h0020, 1'b1, 8'h00);
    tick(2);
    chk("reset_vld", vld, 0);
    chk("reset_id", id, 0);
    chk("reset_il", il, 0);
    chk("reset_hv", hv_o, 0);
    chk("reset_ack", ackv, 0);
    cpurst = 1'b0;
    clear_idle();

    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].req, tbl[k].all, tbl[k].hv, tbl[k].en, tbl[k].th);
      tick(2);
      chk($sformatf("tbl%0d_vld", k), vld, tbl[k].ev);
      if (tbl[k].ev) begin
        chk($sformatf("tbl%0d_id", k), id, tbl[k].eid);
        chk($sformatf("tbl%0d_il", k), il, tbl[k].eil);
        chk($sformatf("tbl%0d_hv", k), hv_o, tbl[k].ehv);
      end
      clear_idle();
    end

    // Single kid: present, ack, then the kid drops its request.
    drive(16'h0020, rk(5, 4'hB), 16'h0, 1'b1, 8'h00);
    tick(2);
    chk("a_vld", vld, 1);
    ack = 1'b1;
    tick(1);
    chk("a_ack", ackv, 16'h0020);
    chk("a_vld_ack", vld, 0);
    ack = 1'b0; req = 16'h0; all = 64'h0;
    tick(1);
    chk("a_ack_once", ackv, 16'h0000);
    tick(3);
    chk("a_vld_after", vld, 0);
    clear_idle();

    // Preemption while presenting: no gap in vld.
    drive(16'h1208, rk(3, 4'hE) | rk(9, 4'hE) | rk(12, 4'hD), 16'h0, 1'b1, 8'h00);
    tick(2);
    chk("b_id_tie", id, 3);
    all = rk(3, 4'hE) | rk(9, 4'hE) | rk(12, 4'hF);
    tick(1);
    chk("b_vld1", vld, 1);
    chk("b_id_old", id, 3);
    tick(1);
    chk("b_vld2", vld, 1);
    chk("b_id_new", id, 12);
    chk("b_il_new", il, 8'hFF);
    clear_idle();

    // A threshold raise while presenting withdraws the interrupt.
    drive(16'h0004, rk(2, 4'hA), 16'h0, 1'b1, 8'h5E);
    tick(2);
    chk("c_vld", vld, 1);
    th = 8'h5F;
    tick(2);
    chk("c_vld_drop", vld, 0);
    clear_idle();

    // An ack in the same cycle as a better candidate.
    drive(16'h0020, rk(5, 4'hB), 16'h0, 1'b1, 8'h00);
    tick(2);
    chk("d_id", id, 5);
    ack = 1'b1; req = 16'h1020; all = rk(5, 4'hB) | rk(12, 4'hF);
    tick(1);
    chk("d_ack", ackv, 16'h0020);
    chk("d_vld0", vld, 0);
    ack = 1'b0; req = 16'h1000; all = rk(12, 4'hF);
    tick(1);
    chk("d_ack_once", ackv, 16'h0000);
    chk("d_vld_drain", vld, 0);
    tick(1);
    chk("d_vld_idle", vld, 0);
    tick(1);
    chk("d_vld_new", vld, 1);
    chk("d_id_new", id, 12);
    clear_idle();

    // A level kid keeps its request and is presented again at t+3.
    drive(16'h0080, rk(7, 4'hC), 16'h0, 1'b1, 8'h00);
    tick(2);
    chk("e_id", id, 7);
    chk("e_il", il, 8'h9F);
    ack = 1'b1;
    tick(1);
    chk("e_ack", ackv, 16'h0080);
    ack = 1'b0;
    tick(1);
    chk("e_vld_t1", vld, 0);
    tick(1);
    chk("e_vld_t2", vld, 0);
    tick(1);
    chk("e_vld_t3", vld, 1);
    chk("e_id_t3", id, 7);

    // Reset during the ack cycle: no pulse, then everything cleared.
    ack = 1'b1;
    tick(1);
    chk("f_ack", ackv, 16'h0080);
    cpurst = 1'b1; ack = 1'b0;
    #1;
    chk("f_ack_rst", ackv, 16'h0000);
    tick(1);
    chk("f_vld", vld, 0);
    chk("f_id", id, 0);
    chk("f_il", il, 0);
    chk("f_ack_after", ackv, 0);
    cpurst = 1'b0;
    tick(2);
    chk("f_vld_again", vld, 1);
    clear_idle();

    // An ack while idle is ignored.
    ack = 1'b1;
    tick(3);
    chk("g_ack_idle", ackv, 0);
    chk("g_vld_idle", vld, 0);
    ack = 1'b0;

    // Random stimulus against the model. It starts with a reset so the
    // model and the DUT share a known state.
    m_pres = 0; m_blk = 0; m_cvld = 0; m_cid = 0; m_crank = 0; m_chv = 0;
    o_id = 0; o_il = 0; o_hv = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cpurst = (cyc < 2) || (cyc % 700 == 350);
      if ($urandom_range(0, 2) == 0) begin
        req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        hv  = 16'($urandom);
        all = '0;
        for (int i = 0; i < N; i++)
          if (req[i]) all[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0:       th = 8'h00;
          1:       th = 8'h3F;
          2:       th = 8'h7F;
          3:       th = 8'h9F;
          default: th = 8'($urandom);
        endcase
      end
      ack = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      exp_ack = (m_blk == 2) ? (16'h1 << o_id) : 16'h0;
      chk("rnd_vld", vld, m_pres);
      chk("rnd_id", id, o_id);
      chk("rnd_il", il, o_il);
      chk("rnd_hv", hv_o, o_hv);
      chk("rnd_ack", ackv, exp_ack);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
